// File: rtl/sha256_loop_ctrl.sv
// sha256_loop_ctrl: sequencer for the 4-slot interleaved SHA-256 compression pipeline.
//   Runs 4 messages in lockstep (one slot per cycle, 64 rounds each) over nblk 512-bit blocks,
//   driving pipeline clear/update strobes, K constants, W scheduler handshakes and digest flags.
// Ports:
//   clk_i, rst_i (async, active-high)       clock / reset
//   start_i, nblk_i                          job request and blocks per message (0 = ignored)
//   busy_o, done_o                           job in progress / 1-cycle completion pulse
//   clr_o, update_o                          pipeline clear and update strobes
//   round_o, slot_o, w_en_o, k_o             current round/slot, W-word enable, K[round_o]
//   blk_idx_o, blk_next_o                    current block index / advance-block pulse
//   digest_valid_o, digest_slot_o            pipeline H00..H07 hold final digest of this slot
module sha256_loop_ctrl #(
    parameter int NBLK_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [NBLK_W-1:0] nblk_i,
    output logic              busy_o,
    output logic              clr_o,
    output logic              update_o,
    output logic [5:0]        round_o,
    output logic [1:0]        slot_o,
    output logic              w_en_o,
    output logic [31:0]       k_o,
    output logic [NBLK_W-1:0] blk_idx_o,
    output logic              blk_next_o,
    output logic              digest_valid_o,
    output logic [1:0]        digest_slot_o,
    output logic              done_o
);
    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, OUT} state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [NBLK_W-1:0] nblk_q, blk_q, blk_idx_q, last_blk;
    logic              busy_q, clr_q, update_q, w_en_q, blk_next_q, dv_q, done_q;
    logic [5:0]        round_q;
    logic [1:0]        slot_q, dslot_q;
    logic              run, c_end;

    assign last_blk = nblk_q - 1'b1;
    assign run      = state_q == RUN;
    assign c_end    = cnt_q == 8'd255;

    assign busy_o         = busy_q;
    assign clr_o          = clr_q;
    assign update_o       = update_q;
    assign round_o        = round_q;
    assign slot_o         = slot_q;
    assign w_en_o         = w_en_q;
    assign k_o            = w_en_q ? K[round_q] : 32'd0;
    assign blk_idx_o      = blk_idx_q;
    assign blk_next_o     = blk_next_q;
    assign digest_valid_o = dv_q;
    assign digest_slot_o  = dslot_q;
    assign done_o         = done_q;

    // Outputs are registered decodes of the current state, so every strobe appears one
    // cycle after the state/counter value that produces it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            nblk_q     <= '0;
            blk_q      <= '0;
            busy_q     <= 1'b0;
            clr_q      <= 1'b0;
            update_q   <= 1'b0;
            w_en_q     <= 1'b0;
            round_q    <= 6'd0;
            slot_q     <= 2'd0;
            blk_idx_q  <= '0;
            blk_next_q <= 1'b0;
            dv_q       <= 1'b0;
            dslot_q    <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            busy_q     <= state_q != IDLE;
            clr_q      <= state_q == INIT;
            // last round of each block plus the first three of the next (or DRAIN) retire the
            // four slots' final additions
            update_q   <= (run && (c_end || (blk_q != '0 && cnt_q < 8'd3))) || state_q == DRAIN;
            w_en_q     <= run;
            round_q    <= run ? cnt_q[7:2] : 6'd0;
            slot_q     <= run ? cnt_q[1:0] : 2'd0;
            blk_idx_q  <= state_q == IDLE ? '0 : blk_q;
            blk_next_q <= run && c_end && blk_q != last_blk;
            dv_q       <= state_q == DRAIN || state_q == OUT;
            dslot_q    <= state_q == DRAIN ? cnt_q[1:0] : state_q == OUT ? 2'd3 : 2'd0;
            done_q     <= state_q == OUT;
            cnt_q      <= cnt_q + 8'd1;
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (start_i && nblk_i != '0) begin
                        state_q <= INIT;
                        nblk_q  <= nblk_i;
                        blk_q   <= '0;
                    end
                end
                INIT: if (cnt_q == 8'd3) begin
                    state_q <= RUN;
                    cnt_q   <= 8'd0;
                end
                RUN: if (c_end) begin
                    // cnt_q wraps to 0 on its own, which also seeds the DRAIN count
                    if (blk_q == last_blk) state_q <= DRAIN;
                    else blk_q <= blk_q + 1'b1;
                end
                DRAIN: if (cnt_q == 8'd2) begin
                    state_q <= OUT;
                    cnt_q   <= 8'd0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end
endmodule
